// File: rtl/scanner_transmitter_pkg.sv
// ---------------------------------------------------------------------------
// scanner_transmitter_pkg
// Framing definitions shared by the scanner transmitter and the transfer
// center receiver. Both sides import this package, so the two ends always
// agree on the frame format.
//   tx_state_t  : line state (IDLE, START, DATA, STOP)
//   DATA_BITS   : payload bits per frame
//   START_LEVEL : line level of the start bit
//   IDLE_LEVEL  : line level while idle, also used for the stop bit
// ---------------------------------------------------------------------------
package scanner_transmitter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b0;

endpackage

// File: rtl/scanner_transmitter_if.sv
// ---------------------------------------------------------------------------
// scanner_transmitter_if
// Bundle of scanner-side load signals, the downstream ready level, the serial
// line and the status outputs of the scanner transmitter.
//   loadData, dataWord : word load request and word from the scanner
//   readyForTransfer   : receiver ready level
//   dataOut            : serial line towards the receiver
//   bufferFull, transmitting, frameDone, overflow, framesSent : status
// Modports: slave = transmitter side, master = scanner/receiver side.
// ---------------------------------------------------------------------------
interface scanner_transmitter_if;
    import scanner_transmitter_pkg::*;

    logic                 loadData;
    logic [DATA_BITS-1:0] dataWord;
    logic                 readyForTransfer;
    logic                 dataOut;
    logic                 bufferFull;
    logic                 transmitting;
    logic                 frameDone;
    logic                 overflow;
    logic [7:0]           framesSent;

    modport slave (
        input  loadData, dataWord, readyForTransfer,
        output dataOut, bufferFull, transmitting, frameDone, overflow, framesSent
    );

    modport master (
        output loadData, dataWord, readyForTransfer,
        input  dataOut, bufferFull, transmitting, frameDone, overflow, framesSent
    );

endinterface

// File: rtl/bit_period_timer.sv
// ---------------------------------------------------------------------------
// bit_period_timer
// Divides the clock into serial bit periods. The count runs 0..BIT_CYCLES-1
// and bitTick is high during the last cycle of each bit period.
//   BIT_CYCLES : clock cycles per serial bit (1..255)
//   clk, rst   : clock and synchronous active-high reset
//   restart    : hold the count at the start of a bit period
//   bitTick    : last cycle of the current bit period
// ---------------------------------------------------------------------------
module bit_period_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bitTick
);

    localparam logic [7:0] LAST_COUNT = 8'(BIT_CYCLES - 1);

    logic [7:0] count;

    // Wrapping at the tick makes every bit boundary restart the period, so
    // with BIT_CYCLES=1 the count stays at 0 and every cycle is a tick.
    always_ff @(posedge clk) begin
        if (rst || restart || bitTick) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign bitTick = (count == LAST_COUNT);

endmodule

// File: rtl/scanner_transmitter.sv
// ---------------------------------------------------------------------------
// scanner_transmitter
// Takes 8-bit words from the scanner into a one-word holding buffer and sends
// each one on a single serial line as start bit, 8 data bits LSB-first and a
// stop bit, once the downstream receiver signals ready.
//   BIT_CYCLES : clock cycles per serial bit (1..255)
//   clk, rst   : clock and synchronous active-high reset
//   bus        : scanner_transmitter_if.slave (load, ready, line, status)
// ---------------------------------------------------------------------------
module scanner_transmitter
    import scanner_transmitter_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    scanner_transmitter_if.slave  bus
);

    localparam logic [2:0] LAST_INDEX = 3'(DATA_BITS - 1);

    tx_state_t            state;
    tx_state_t            state_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [DATA_BITS-1:0] hold_buf;
    logic [2:0]           bit_index;
    logic [2:0]           index_next;
    logic                 buffer_full;
    logic                 line_reg;
    logic                 line_next;
    logic                 frame_done;
    logic                 overflow_flag;
    logic [7:0]           frame_count;
    logic                 bit_tick;
    logic                 take_word;
    logic                 frame_end;
    logic                 load_accept;

    // The timer is held at the start of a period while idle so that the
    // first start bit gets its full length.
    bit_period_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (state == IDLE),
        .bitTick (bit_tick)
    );

    always_comb begin
        state_next  = state;
        shift_next  = shift_reg;
        index_next  = bit_index;
        take_word   = 1'b0;
        frame_end   = 1'b0;
        line_next   = IDLE_LEVEL;
        load_accept = 1'b0;

        case (state)
            IDLE: begin
                if (buffer_full && bus.readyForTransfer) begin
                    take_word  = 1'b1;
                    shift_next = hold_buf;
                    state_next = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    index_next = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_next = shift_reg >> 1;
                    index_next = bit_index + 3'd1;
                    if (bit_index == LAST_INDEX) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Ready is only looked at here and in IDLE; a buffered word
                // with ready high chains straight into the next start bit.
                if (bit_tick) begin
                    frame_end = 1'b1;
                    if (buffer_full && bus.readyForTransfer) begin
                        take_word  = 1'b1;
                        shift_next = hold_buf;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The line is a register, so its value is decoded from the state
        // and shifter contents that will hold after this edge.
        case (state_next)
            START:   line_next = START_LEVEL;
            DATA:    line_next = shift_next[0];
            default: line_next = IDLE_LEVEL;
        endcase

        // A word leaving the buffer this cycle frees the slot for a new load.
        load_accept = bus.loadData && (!buffer_full || take_word);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shift_reg     <= '0;
            bit_index     <= '0;
            hold_buf      <= '0;
            buffer_full   <= 1'b0;
            line_reg      <= IDLE_LEVEL;
            frame_done    <= 1'b0;
            overflow_flag <= 1'b0;
            frame_count   <= '0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_index  <= index_next;
            line_reg   <= line_next;
            frame_done <= frame_end;
            if (frame_end) begin
                frame_count <= frame_count + 8'd1;
            end
            if (load_accept) begin
                hold_buf    <= bus.dataWord;
                buffer_full <= 1'b1;
            end else if (take_word) begin
                buffer_full <= 1'b0;
            end
            if (bus.loadData && !load_accept) begin
                overflow_flag <= 1'b1;
            end
        end
    end

    assign bus.dataOut      = line_reg;
    assign bus.bufferFull   = buffer_full;
    assign bus.transmitting = (state != IDLE);
    assign bus.frameDone    = frame_done;
    assign bus.overflow     = overflow_flag;
    assign bus.framesSent   = frame_count;

endmodule
